// File: rtl/rll_seq_key_unit.sv
// rll_seq_key_unit: serially loaded XOR/XNOR key gates on NETS nets.
// Optional trailing even-parity check enabled by defining KEY_PARITY_EN.
module rll_seq_key_unit #(
  parameter int              NETS     = 32,
  parameter logic [NETS-1:0] POL_MASK = '0,
  parameter int              PIPE     = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_start,
  input  logic            key_valid,
  input  logic            key_bit,
  output logic            key_ready,
  output logic            key_loaded,
`ifdef KEY_PARITY_EN
  output logic            key_err,
`endif
  input  logic [NETS-1:0] net_in,
  output logic [NETS-1:0] net_out
);

  localparam int CW = $clog2(NETS + 1);
  localparam logic [CW-1:0] LAST = CW'(NETS - 1);

`ifdef KEY_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR,
    COMMIT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NETS-1:0] key_sh;
  logic [NETS-1:0] key_act;
  logic [NETS-1:0] gated;

  // Ready is a pure decode of the registered state.
  always_comb begin
    key_ready = 1'b0;
    if (state == SHIFT)
      key_ready = 1'b1;
`ifdef KEY_PARITY_EN
    if (state == PAR)
      key_ready = 1'b1;
`endif
  end

  // Load FSM: shifts key bits in, then swaps the applied key atomically.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      key_sh     <= '0;
      key_act    <= '0;
      key_loaded <= 1'b0;
`ifdef KEY_PARITY_EN
      key_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (key_start) begin
            state  <= SHIFT;
            cnt    <= '0;
            key_sh <= '0;
`ifdef KEY_PARITY_EN
            key_err <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (key_start) begin
            cnt    <= '0;
            key_sh <= '0;
`ifdef KEY_PARITY_EN
            key_err <= 1'b0;
`endif
          end else if (key_valid) begin
            for (int i = 0; i < NETS; i++) begin
              if (cnt == CW'(i))
                key_sh[i] <= key_bit;
            end
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
`ifdef KEY_PARITY_EN
              state <= PAR;
`else
              state <= COMMIT;
`endif
            end
          end
        end
`ifdef KEY_PARITY_EN
        PAR: begin
          if (key_start) begin
            state   <= SHIFT;
            cnt     <= '0;
            key_sh  <= '0;
            key_err <= 1'b0;
          end else if (key_valid) begin
            if ((^key_sh) ^ key_bit) begin
              key_err <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= COMMIT;
            end
          end
        end
`endif
        COMMIT: begin
          key_act    <= key_sh;
          key_loaded <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Key gates: a zero result after the mask means the correct key bit.
  always_comb begin
    gated = net_in ^ key_act ^ POL_MASK;
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic [NETS-1:0] net_q;

      // Output register runs every cycle, independent of the FSM.
      always_ff @(posedge clk) begin
        if (!rst_n)
          net_q <= '0;
        else
          net_q <= gated;
      end

      assign net_out = net_q;
    end else begin : g_comb
      assign net_out = gated;
    end
  endgenerate

endmodule

// File: tb/tb_rll_seq_key_unit.sv
// tb_rll_seq_key_unit: directed checks of rll_seq_key_unit, NETS=8.
// Runs a PIPE=0 and a PIPE=1 instance side by side on shared inputs.
module tb_rll_seq_key_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_start;
  logic       key_valid;
  logic       key_bit;
  logic [7:0] net_in;
  logic       key_ready;
  logic       key_loaded;
  logic [7:0] net_out;
  logic       p_ready;
  logic       p_loaded;
  logic [7:0] p_net_out;
`ifdef KEY_PARITY_EN
  logic       key_err;
  logic       p_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rll_seq_key_unit #(
    .NETS(8), .POL_MASK(8'hA5), .PIPE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_start(key_start), .key_valid(key_valid), .key_bit(key_bit),
    .key_ready(key_ready), .key_loaded(key_loaded),
`ifdef KEY_PARITY_EN
    .key_err(key_err),
`endif
    .net_in(net_in), .net_out(net_out)
  );

  rll_seq_key_unit #(
    .NETS(8), .POL_MASK(8'hA5), .PIPE(1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n),
    .key_start(key_start), .key_valid(key_valid), .key_bit(key_bit),
    .key_ready(p_ready), .key_loaded(p_loaded),
`ifdef KEY_PARITY_EN
    .key_err(p_err),
`endif
    .net_in(net_in), .net_out(p_net_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    key_valid = 1'b1;
    key_bit   = b;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] k, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(k[i]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; key_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
    net_in = 8'h3C;
    tick(); tick();
    checks++;
    if (net_out !== 8'h99) begin
      errors++; $display("FAIL reset_net got %h exp 99", net_out);
    end
    checks++;
    if (key_loaded !== 1'b0 || key_ready !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %b%b exp 00", key_loaded, key_ready);
    end
    checks++;
    if (p_net_out !== 8'h00) begin
      errors++; $display("FAIL reset_pipe got %h exp 00", p_net_out);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (p_net_out !== 8'h99) begin
      errors++; $display("FAIL pipe_after_reset got %h exp 99", p_net_out);
    end
  endtask

  task automatic test_load;
    start_pulse();
    checks++;
    if (key_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready got %b exp 1", key_ready);
    end
    send_bits(8'hA5, 0, 7);
    checks++;
    if (key_loaded !== 1'b0 || key_ready !== 1'b0 || net_out !== 8'h99) begin
      errors++;
      $display("FAIL load_commit_cycle got %b %b %h exp 0 0 99",
               key_loaded, key_ready, net_out);
    end
    tick();
    checks++;
    if (key_loaded !== 1'b1 || net_out !== 8'h3C) begin
      errors++; $display("FAIL load_done got %b %h exp 1 3c", key_loaded, net_out);
    end
    checks++;
    if (p_net_out !== 8'h99) begin
      errors++; $display("FAIL load_pipe_lag got %h exp 99", p_net_out);
    end
    tick();
    checks++;
    if (p_net_out !== 8'h3C) begin
      errors++; $display("FAIL load_pipe got %h exp 3c", p_net_out);
    end
  endtask

  task automatic test_reload_hold;
    start_pulse();
    send_bits(8'h00, 0, 3);
    tick(); tick(); tick();
    checks++;
    if (net_out !== 8'h3C || key_loaded !== 1'b1 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_hold got %h %b %b exp 3c 1 1",
               net_out, key_loaded, key_ready);
    end
    send_bits(8'h00, 4, 7);
    checks++;
    if (net_out !== 8'h3C) begin
      errors++; $display("FAIL reload_pre_commit got %h exp 3c", net_out);
    end
    tick();
    checks++;
    if (net_out !== 8'h99) begin
      errors++; $display("FAIL reload_done got %h exp 99", net_out);
    end
  endtask

  task automatic test_restart;
    start_pulse();
    send_bits(8'h5A, 0, 6);
    key_start = 1'b1;
    send_bit(1'b1);
    key_start = 1'b0;
    tick(); tick();
    checks++;
    if (key_ready !== 1'b1 || net_out !== 8'h99) begin
      errors++;
      $display("FAIL restart_drop got %b %h exp 1 99", key_ready, net_out);
    end
    send_bits(8'hA5, 0, 6);
    tick();
    checks++;
    if (key_ready !== 1'b1 || net_out !== 8'h99) begin
      errors++;
      $display("FAIL restart_fresh_needed got %b %h exp 1 99", key_ready, net_out);
    end
    send_bit(1'b1);
    tick();
    checks++;
    if (net_out !== 8'h3C || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_done got %h %b exp 3c 0", net_out, key_ready);
    end
  endtask

  task automatic test_ignore;
    send_bits(8'hFF, 0, 3);
    checks++;
    if (key_ready !== 1'b0 || net_out !== 8'h3C) begin
      errors++;
      $display("FAIL idle_valid got %b %h exp 0 3c", key_ready, net_out);
    end
    start_pulse();
    send_bits(8'hA5, 0, 7);
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    checks++;
    if (key_ready !== 1'b0 || key_loaded !== 1'b1) begin
      errors++;
      $display("FAIL commit_start got %b %b exp 0 1", key_ready, key_loaded);
    end
  endtask

  task automatic test_patterns;
    logic [7:0] v [4] = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    for (int i = 0; i < 4; i++) begin
      net_in = v[i];
      tick();
      checks++;
      if (net_out !== v[i] || p_net_out !== v[i]) begin
        errors++;
        $display("FAIL pattern_%0d got %h %h exp %h", i, net_out, p_net_out, v[i]);
      end
    end
    net_in = 8'h3C;
    tick();
  endtask

  task automatic test_midload_reset;
    start_pulse();
    send_bits(8'h00, 0, 4);
    rst_n = 1'b0;
    tick();
    checks++;
    if (net_out !== 8'h99 || key_loaded !== 1'b0 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset got %h %b %b exp 99 0 0",
               net_out, key_loaded, key_ready);
    end
    checks++;
    if (p_net_out !== 8'h00) begin
      errors++; $display("FAIL midload_reset_pipe got %h exp 00", p_net_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

`ifdef KEY_PARITY_EN
  task automatic test_parity;
    start_pulse();
    send_bits(8'hA5, 0, 7);
    send_bit(1'b0);
    tick();
    checks++;
    if (net_out !== 8'h3C || key_err !== 1'b0 || key_loaded !== 1'b1) begin
      errors++;
      $display("FAIL parity_ok got %h %b %b exp 3c 0 1",
               net_out, key_err, key_loaded);
    end
    start_pulse();
    send_bits(8'h00, 0, 7);
    send_bit(1'b1);
    tick();
    checks++;
    if (net_out !== 8'h3C || key_err !== 1'b1 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad got %h %b %b exp 3c 1 0",
               net_out, key_err, key_ready);
    end
    start_pulse();
    send_bits(8'hA5, 0, 7);
    send_bit(1'b1);
    tick();
    checks++;
    if (key_err !== 1'b1 || key_loaded !== 1'b1 || net_out !== 8'h3C) begin
      errors++;
      $display("FAIL parity_bad_same got %b %b %h exp 1 1 3c",
               key_err, key_loaded, net_out);
    end
    start_pulse();
    checks++;
    if (key_err !== 1'b0) begin
      errors++; $display("FAIL parity_clear got %b exp 0", key_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_reload_hold();
    test_restart();
    test_ignore();
    test_patterns();
    test_midload_reset();
`ifdef KEY_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
